// File: rtl/clk_mode_sequencer.sv
// Four-mode display sequencer: button-driven mode FSM, prescaled step strobes at
// 1/2 or 1/3 of the tick rate, a 3-bit LFSR advanced by those strobes, and LED select.
module clk_mode_sequencer #(
    parameter int         PRESCALE  = 12_500_000,
    parameter int         PS_W      = 24,
    parameter logic [2:0] LFSR_SEED = 3'b001
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       advance,
    input  logic       home,
    output logic [1:0] mode,
    output logic       step,
    output logic [2:0] led
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_ALL_ON = 2'b01,
        ST_DIV2   = 2'b10,
        ST_DIV3   = 2'b11
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    function automatic logic [2:0] lfsr_advance(input logic [2:0] value);
        return {value[1:0], value[2] ^ value[1]};
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              adv_q_r;
    logic              adv_rise_s;
    logic              change_s;
    logic              running_s;
    logic              tick_s;
    logic              step_due_s;
    logic [1:0]        div_last_s;
    logic [PS_W-1:0]   ps_cnt_r;
    logic [PS_W-1:0]   ps_next_s;
    logic [1:0]        div_cnt_r;
    logic [1:0]        div_next_s;
    logic [2:0]        lfsr_r;
    logic [2:0]        lfsr_next_s;
    logic [2:0]        led_next_s;
    logic              step_r;
    logic [2:0]        led_r;

    assign adv_rise_s = advance & ~adv_q_r;
    assign change_s   = home | adv_rise_s;
    assign running_s  = (state_r == ST_DIV2) || (state_r == ST_DIV3);
    assign div_last_s = (state_r == ST_DIV2) ? 2'd1 : 2'd2;

    // Mode transitions; home outranks a button edge.
    always_comb begin
        state_next_s = state_r;
        if (home) begin
            state_next_s = ST_INIT;
        end else if (adv_rise_s) begin
            case (state_r)
                ST_INIT:   state_next_s = ST_ALL_ON;
                ST_ALL_ON: state_next_s = ST_DIV2;
                ST_DIV2:   state_next_s = ST_DIV3;
                ST_DIV3:   state_next_s = ST_DIV2;
                default:   state_next_s = ST_INIT;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Prescaler and divider; a mode change restarts both and swallows a due step.
    always_comb begin
        ps_next_s  = {PS_W{1'b0}};
        div_next_s = 2'd0;
        tick_s     = 1'b0;
        step_due_s = 1'b0;
        if (change_s || !running_s) begin
            ps_next_s  = {PS_W{1'b0}};
            div_next_s = 2'd0;
        end else begin
            tick_s = (ps_cnt_r == PS_LAST);
            if (tick_s) begin
                ps_next_s = {PS_W{1'b0}};
                if (div_cnt_r == div_last_s) begin
                    div_next_s = 2'd0;
                    step_due_s = 1'b1;
                end else begin
                    div_next_s = div_cnt_r + 2'd1;
                end
            end else begin
                ps_next_s  = ps_cnt_r + PS_W'(1);
                div_next_s = div_cnt_r;
            end
        end
    end

    // LFSR steps on the visible strobe; LED follows the upcoming mode and LFSR value.
    always_comb begin
        lfsr_next_s = lfsr_r;
        led_next_s  = 3'b000;
        if ((state_r == ST_INIT) || (state_next_s == ST_INIT)) begin
            lfsr_next_s = LFSR_SEED;
        end else if (step_r) begin
            lfsr_next_s = lfsr_advance(lfsr_r);
        end else begin
            lfsr_next_s = lfsr_r;
        end
        case (state_next_s)
            ST_INIT:   led_next_s = 3'b000;
            ST_ALL_ON: led_next_s = 3'b111;
            ST_DIV2:   led_next_s = lfsr_next_s;
            ST_DIV3:   led_next_s = lfsr_next_s;
            default:   led_next_s = 3'b000;
        endcase
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_INIT;
            adv_q_r   <= 1'b0;
            ps_cnt_r  <= {PS_W{1'b0}};
            div_cnt_r <= 2'd0;
            lfsr_r    <= LFSR_SEED;
            step_r    <= 1'b0;
            led_r     <= 3'b000;
        end else begin
            state_r   <= state_next_s;
            adv_q_r   <= advance;
            ps_cnt_r  <= ps_next_s;
            div_cnt_r <= div_next_s;
            lfsr_r    <= lfsr_next_s;
            step_r    <= step_due_s;
            led_r     <= led_next_s;
        end
    end

    assign mode = state_r;
    assign step = step_r;
    assign led  = led_r;

endmodule

// File: tb/tb_clk_mode_sequencer.sv
// Scoreboard bench: two sequencers (PRESCALE 1 and 4) share one stimulus stream and
// are checked each cycle against an elapsed-cycle reference model.
module tb_clk_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       advance = 1'b0;
    logic       home = 1'b0;
    logic [1:0] mode1, mode4;
    logic       step1, step4;
    logic [2:0] led1, led4;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [5:0] p1;
        logic [5:0] p4;
    } exp_t;

    exp_t q[$];

    // reference model state, index 0 for PRESCALE=1, index 1 for PRESCALE=4
    int         pval [2] = '{1, 4};
    int         m_mode [2];
    int         m_j [2];
    logic       m_step [2];
    int         m_idx [2];
    logic       m_adv [2];
    int         succ [4] = '{1, 2, 3, 2};
    logic [2:0] seq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};

    always #5 clk = ~clk;

    clk_mode_sequencer #(.PRESCALE(1), .PS_W(4), .LFSR_SEED(3'b001)) u_dut1 (
        .clock_in(clk), .reset(reset), .advance(advance), .home(home),
        .mode(mode1), .step(step1), .led(led1)
    );

    clk_mode_sequencer #(.PRESCALE(4), .PS_W(4), .LFSR_SEED(3'b001)) u_dut4 (
        .clock_in(clk), .reset(reset), .advance(advance), .home(home),
        .mode(mode4), .step(step4), .led(led4)
    );

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got mode/step/led=%b want %b", name, $time, act, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_j[k] = 0; m_step[k] = 1'b0; m_idx[k] = 0; m_adv[k] = 1'b0;
        end
    endtask

    task automatic model_cycle(input logic a, input logic h, output exp_t e);
        logic [5:0] o [2];
        for (int k = 0; k < 2; k++) begin
            logic rise, chg, due;
            int nm, n;
            rise = a & ~m_adv[k];
            chg  = h | rise;
            nm   = h ? 0 : (rise ? succ[m_mode[k]] : m_mode[k]);
            n    = (m_mode[k] == 2) ? 2 : 3;
            due  = (m_mode[k] >= 2) && !chg && (((m_j[k] + 1) % (n * pval[k])) == 0);
            if (m_mode[k] == 0 || nm == 0) m_idx[k] = 0;
            else if (m_step[k]) m_idx[k] = (m_idx[k] + 1) % 7;
            m_j[k]    = chg ? 0 : ((m_mode[k] >= 2) ? m_j[k] + 1 : 0);
            m_step[k] = due;
            m_mode[k] = nm;
            m_adv[k]  = a;
            o[k] = {nm[1:0], due, (nm == 0) ? 3'b000 : ((nm == 1) ? 3'b111 : seq[m_idx[k]])};
        end
        e.p1 = o[0];
        e.p4 = o[1];
    endtask

    task automatic cyc(input logic a, input logic h);
        exp_t e;
        @(negedge clk);
        advance = a;
        home = h;
        model_cycle(a, h, e);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic pulse(input int gap);
        cyc(1'b1, 1'b0);
        idle(gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_p1"}, {mode1, step1, led1}, 6'b000000);
        chk({tag, "_p4"}, {mode4, step4, led4}, 6'b000000);
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_p1", {mode1, step1, led1}, e.p1);
            chk("sb_p4", {mode4, step4, led4}, e.p4);
        end
    end

    initial begin
        logic a;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #3;
        check_reset_outputs("reset_init");
        @(negedge clk);
        reset = 1'b1;

        idle(20);
        pulse(3);                                   // INIT -> ALL_ON
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0); // held level: one step to DIV2
        idle(30);
        pulse(40);                                  // DIV2 -> DIV3
        for (int i = 0; i < 4; i++) pulse(10);      // toggles DIV2/DIV3
        for (int i = 0; i < 6; i++) pulse(i);       // edges landing on assorted step phases
        cyc(1'b1, 1'b1);                            // home beats advance
        idle(5);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1); // home while in INIT

        a = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) a = ~a;
            cyc(a, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        idle(1);
        cyc(1'b1, 1'b1);
        idle(1);
        pulse(1); pulse(1); pulse(1);               // reach DIV3
        idle(7);
        @(negedge clk);                             // let the last expectation drain
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(10);

        a = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) a = ~a;
            cyc(a, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
